fetch_queue: RTL and testbench

- Parametrised successor to the single-PC fetch stage.
- Decouples PC generation from the instruction memory with a valid/ready request port and an in-order response port.
- Buffers returned instructions in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
- Supports branch/jump redirects that flush the FIFO and discard stale in-flight responses; decode stalls do not lose instructions.

---
 rtl/fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_fetch_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch front end.
//
// The PC generator issues one request per cycle to instruction memory over a
// valid/ready port. Instructions come back in order and go into a DEPTH-entry
// FIFO, which decode drains through a valid/ready handshake. A new request is
// only issued while a FIFO slot is free for it, so a response is never refused.
// Branch and jump redirects flush the FIFO and discard the responses still in
// flight.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   ireq_valid/ready    fetch request handshake; ireq_addr is the current PC
//   iresp_valid/data    in-order instruction return, at most one per cycle
//   branch_judge/address  redirect (takes priority over jump)
//   jump_judge/address    redirect
//   out_valid/ready     FIFO head handshake towards decode
//   out_instruction     head instruction, plus its PC, PC+4 and rs/rt fields
//   occupancy           number of FIFO entries
module fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ireq_valid,
  output logic [ADDR_W-1:0]          ireq_addr,
  input  logic                       ireq_ready,
  input  logic                       iresp_valid,
  input  logic [31:0]                iresp_data,
  input  logic                       branch_judge,
  input  logic [ADDR_W-1:0]          branch_address,
  input  logic                       jump_judge,
  input  logic [ADDR_W-1:0]          jump_address,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instruction,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus_4,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned SH_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [ADDR_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [OUT_W-1:0]  outstanding, outstanding_next;
  logic [OUT_W-1:0]  drop, drop_next;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [SH_W-1:0]   sh_rd, sh_wr;

  logic [ADDR_W-1:0] sh_pc    [MAX_OUT];
  logic [31:0]       instr_mem[DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              req_fire;
  logic              resp_drop;
  logic              push;
  logic              pop;
  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;

  assign redirect = branch_judge | jump_judge;
  assign target   = branch_judge ? branch_address : jump_address;

  // Every live request holds a FIFO slot, so outstanding + count bounds
  // issue; requests are held off while reset is asserted.
  assign ireq_valid = reset
                    && ((int'(outstanding) + int'(count)) < int'(DEPTH))
                    && (int'(outstanding) < int'(MAX_OUT))
                    && !redirect;
  assign ireq_addr  = pc;
  assign req_fire   = ireq_valid & ireq_ready;

  assign resp_drop = iresp_valid & (redirect | (drop != '0));
  assign push      = iresp_valid & ~resp_drop;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    pc_next          = pc;
    count_next       = count;
    outstanding_next = outstanding + OUT_W'(req_fire) - OUT_W'(iresp_valid);
    drop_next        = drop;

    if (redirect) begin
      pc_next    = target;
      count_next = '0;
      // Everything still outstanding after this cycle is stale; a response
      // discarded this cycle is already removed from outstanding_next.
      drop_next  = outstanding_next;
    end else begin
      if (req_fire) begin
        pc_next = pc + ADDR_W'(4);
      end
      count_next = count + CNT_W'(push) - CNT_W'(pop);
      if (iresp_valid && (drop != '0)) begin
        drop_next = drop - OUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sh_rd       <= '0;
      sh_wr       <= '0;
    end else begin
      pc          <= pc_next;
      count       <= count_next;
      outstanding <= outstanding_next;
      drop        <= drop_next;
      if (req_fire) begin
        sh_wr <= (sh_wr == SH_W'(MAX_OUT - 1)) ? '0 : sh_wr + SH_W'(1);
      end
      if (iresp_valid) begin
        sh_rd <= (sh_rd == SH_W'(MAX_OUT - 1)) ? '0 : sh_rd + SH_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      // Flush empties the FIFO by snapping the read side onto the write side.
      if (redirect) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      sh_pc[sh_wr] <= pc;
    end
    if (push) begin
      instr_mem[wr_ptr] <= iresp_data;
      pc_mem[wr_ptr]    <= sh_pc[sh_rd];
    end
  end

  assign head_instr      = instr_mem[rd_ptr];
  assign head_pc         = pc_mem[rd_ptr];
  assign out_instruction = out_valid ? head_instr : '0;
  assign out_pc          = out_valid ? head_pc : '0;
  assign out_pc_plus_4   = out_valid ? head_pc + ADDR_W'(4) : '0;
  assign out_rs          = out_instruction[25:21];
  assign out_rt          = out_instruction[20:16];
  assign occupancy       = count;

  a_resp_needs_request: assert property (
    @(posedge clk) disable iff (!reset) iresp_valid |-> (outstanding != '0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset) push |-> (count != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue. A second instance with RESET_PC near the
// top of the address space shares every input with the main instance; its
// request timing is identical, so the same imem responses serve both.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_ready, iresp_valid, branch_judge, jump_judge, out_ready;
  logic [31:0] iresp_data, branch_address, jump_address;

  logic        ireq_valid, out_valid;
  logic [31:0] ireq_addr, out_instruction, out_pc, out_pc_plus_4;
  logic [4:0]  out_rs, out_rt;
  logic [2:0]  occupancy;

  logic        w_ireq_valid, w_out_valid;
  logic [31:0] w_ireq_addr, w_out_instruction, w_out_pc, w_out_pc_plus_4;
  logic [4:0]  w_out_rs, w_out_rt;
  logic [2:0]  w_occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .branch_judge(branch_judge), .branch_address(branch_address),
    .jump_judge(jump_judge), .jump_address(jump_address),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_rs(out_rs), .out_rt(out_rt),
    .occupancy(occupancy)
  );

  fetch_queue #(.ADDR_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset),
    .ireq_valid(w_ireq_valid), .ireq_addr(w_ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .branch_judge(branch_judge), .branch_address(branch_address),
    .jump_judge(jump_judge), .jump_address(jump_address),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instruction(w_out_instruction),
    .out_pc(w_out_pc), .out_pc_plus_4(w_out_pc_plus_4), .out_rs(w_out_rs), .out_rt(w_out_rt),
    .occupancy(w_occupancy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // imem model state: in-order queue of issued addresses and capture edge.
  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];

  // Everything decode consumed (main instance) and PCs consumed (wrap instance).
  logic [31:0] rx_pc[$], rx_instr[$], rx_pc4[$];
  logic [4:0]  rx_rs[$], rx_rt[$];
  logic [31:0] wrx_pc[$], wrx_pc4[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
  endfunction

  // One clock cycle. Entered near a falling edge with inputs set; samples the
  // handshakes before the rising edge, then updates the imem response.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = ireq_valid && ireq_ready;
    a  = ireq_addr;
    if (out_valid && out_ready) begin
      rx_pc.push_back(out_pc);
      rx_instr.push_back(out_instruction);
      rx_pc4.push_back(out_pc_plus_4);
      rx_rs.push_back(out_rs);
      rx_rt.push_back(out_rt);
    end
    if (w_out_valid && out_ready) begin
      wrx_pc.push_back(w_out_pc);
      wrx_pc4.push_back(w_out_pc_plus_4);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (hs) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat);
    end
    iresp_valid = 1'b0;
    iresp_data  = '0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc + 1) begin
      iresp_valid = 1'b1;
      iresp_data  = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    iresp_valid  = 1'b0;
    iresp_data   = '0;
    branch_judge = 1'b0;
    jump_judge   = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    ireq_ready = 1'b1;
    branch_address = '0;
    jump_address = '0;
    lat = 1;
    reset = 1'b0;
    iresp_valid = 1'b0;
    iresp_data = '0;
    branch_judge = 1'b0;
    jump_judge = 1'b0;
    repeat (2) tick();
    #1;
    n_checks++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ireq_valid: got %b expected 0", ireq_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (out_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_out_instruction: got %h expected 0", out_instruction); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc_plus_4: got %h expected 0", out_pc_plus_4); end
    reset = 1'b1;
    #1;
    n_checks++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b expected 1", ireq_valid); end
    n_checks++; if (ireq_addr !== 32'h0) begin n_fail++; $display("FAIL first_req_addr: got %h expected 0", ireq_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_no_pop_valid: got %b expected 0", out_valid); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL empty_no_pop_occ: got %0d expected 0", occupancy); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL latency_pc: got %h expected 0", out_pc); end
  endtask

  task automatic test_straight_line();
    logic [31:0] e;
    apply_reset();
    lat = 1;
    out_ready = 1'b1;
    rx_pc.delete(); rx_instr.delete(); rx_pc4.delete(); rx_rs.delete(); rx_rt.delete();
    repeat (12) tick();
    n_checks++; if (rx_pc.size() != 10) begin n_fail++; $display("FAIL straight_count: got %0d expected 10", rx_pc.size()); end
    n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL straight_occupancy: got %0d expected 1", occupancy); end
    for (int i = 0; i < rx_pc.size(); i++) begin
      e = 32'(4 * i);
      n_checks++; if (rx_pc[i] !== e) begin n_fail++; $display("FAIL straight_pc[%0d]: got %h expected %h", i, rx_pc[i], e); end
      n_checks++; if (rx_pc4[i] !== e + 32'd4) begin n_fail++; $display("FAIL straight_pc4[%0d]: got %h expected %h", i, rx_pc4[i], e + 32'd4); end
      e = instr_of(32'(4 * i));
      n_checks++; if (rx_instr[i] !== e) begin n_fail++; $display("FAIL straight_instr[%0d]: got %h expected %h", i, rx_instr[i], e); end
      n_checks++; if (rx_rs[i] !== e[25:21]) begin n_fail++; $display("FAIL straight_rs[%0d]: got %h expected %h", i, rx_rs[i], e[25:21]); end
      n_checks++; if (rx_rt[i] !== e[20:16]) begin n_fail++; $display("FAIL straight_rt[%0d]: got %h expected %h", i, rx_rt[i], e[20:16]); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    repeat (10) tick();
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy); end
    n_checks++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ireq_valid: got %b expected 0", ireq_valid); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (rx_pc.size() != 10) begin n_fail++; $display("FAIL bp_no_pop: got %0d expected 10", rx_pc.size()); end
    out_ready = 1'b1;
    repeat (12) tick();
    n_checks++; if (rx_pc.size() != 22) begin n_fail++; $display("FAIL bp_total: got %0d expected 22", rx_pc.size()); end
    for (int i = 0; i < rx_pc.size(); i++) begin
      n_checks++; if (rx_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, rx_pc[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_branch_redirect();
    int          inflight;
    int unsigned guard;
    lat = 3;
    guard = 0;
    inflight = pend_addr.size() + int'(iresp_valid);
    while (inflight != 2 && guard < 20) begin
      tick();
      guard++;
      inflight = pend_addr.size() + int'(iresp_valid);
    end
    n_checks++; if (inflight != 2) begin n_fail++; $display("FAIL br_inflight: got %0d expected 2", inflight); end
    branch_judge = 1'b1;
    branch_address = 32'h0000_0100;
    tick();
    branch_judge = 1'b0;
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL br_flush_occ: got %0d expected 0", occupancy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush_valid: got %b expected 0", out_valid); end
    n_checks++; if (ireq_addr !== 32'h100) begin n_fail++; $display("FAIL br_ireq_addr: got %h expected 00000100", ireq_addr); end
    rx_pc.delete(); rx_instr.delete(); rx_pc4.delete(); rx_rs.delete(); rx_rt.delete();
    guard = 0;
    while (rx_pc.size() < 3 && guard < 40) begin
      tick();
      guard++;
    end
    n_checks++; if (rx_pc.size() < 3) begin n_fail++; $display("FAIL br_timeout: got %0d entries expected 3", rx_pc.size()); end
    else begin
      n_checks++; if (rx_pc[0] !== 32'h100) begin n_fail++; $display("FAIL br_pc0: got %h expected 00000100", rx_pc[0]); end
      n_checks++; if (rx_pc[1] !== 32'h104) begin n_fail++; $display("FAIL br_pc1: got %h expected 00000104", rx_pc[1]); end
      n_checks++; if (rx_pc[2] !== 32'h108) begin n_fail++; $display("FAIL br_pc2: got %h expected 00000108", rx_pc[2]); end
      n_checks++; if (rx_instr[0] !== instr_of(32'h100)) begin n_fail++; $display("FAIL br_instr0: got %h expected %h", rx_instr[0], instr_of(32'h100)); end
    end
  endtask

  task automatic test_dual_redirect();
    int unsigned guard;
    lat = 1;
    branch_judge = 1'b1;
    branch_address = 32'h0000_0040;
    jump_judge = 1'b1;
    jump_address = 32'h0000_0080;
    #1;
    n_checks++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL dual_no_req: got %b expected 0", ireq_valid); end
    tick();
    branch_judge = 1'b0;
    jump_judge = 1'b0;
    n_checks++; if (ireq_addr !== 32'h40) begin n_fail++; $display("FAIL dual_ireq_addr: got %h expected 00000040", ireq_addr); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL dual_flush_occ: got %0d expected 0", occupancy); end
    rx_pc.delete(); rx_instr.delete(); rx_pc4.delete(); rx_rs.delete(); rx_rt.delete();
    guard = 0;
    while (rx_pc.size() < 2 && guard < 30) begin
      tick();
      guard++;
    end
    n_checks++; if (rx_pc.size() < 2) begin n_fail++; $display("FAIL dual_timeout: got %0d entries expected 2", rx_pc.size()); end
    else begin
      n_checks++; if (rx_pc[0] !== 32'h40) begin n_fail++; $display("FAIL dual_pc0: got %h expected 00000040", rx_pc[0]); end
      n_checks++; if (rx_pc4[0] !== 32'h44) begin n_fail++; $display("FAIL dual_pc4_0: got %h expected 00000044", rx_pc4[0]); end
      n_checks++; if (rx_pc[1] !== 32'h44) begin n_fail++; $display("FAIL dual_pc1: got %h expected 00000044", rx_pc[1]); end
    end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    lat = 1;
    out_ready = 1'b1;
    #1;
    n_checks++; if (w_ireq_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_reset_pc: got %h expected fffffff8", w_ireq_addr); end
    wrx_pc.delete();
    wrx_pc4.delete();
    repeat (6) tick();
    n_checks++; if (wrx_pc.size() < 3) begin n_fail++; $display("FAIL wrap_count: got %0d expected >=3", wrx_pc.size()); end
    else begin
      n_checks++; if (wrx_pc[0] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_pc0: got %h expected fffffff8", wrx_pc[0]); end
      n_checks++; if (wrx_pc[1] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc1: got %h expected fffffffc", wrx_pc[1]); end
      n_checks++; if (wrx_pc[2] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc2: got %h expected 00000000", wrx_pc[2]); end
      n_checks++; if (wrx_pc4[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc4_0: got %h expected fffffffc", wrx_pc4[0]); end
      n_checks++; if (wrx_pc4[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc4_1: got %h expected 00000000", wrx_pc4[1]); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    lat = 1;
    out_ready = 1'b0;
    repeat (4) tick();
    n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL ar_pre_occ: got %0d expected 3", occupancy); end
    #2;
    reset = 1'b0;
    iresp_valid = 1'b0;
    iresp_data = '0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL ar_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL ar_ireq_valid: got %b expected 0", ireq_valid); end
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++; if (ireq_addr !== 32'h0) begin n_fail++; $display("FAIL ar_ireq_addr: got %h expected 00000000", ireq_addr); end
    n_checks++; if (w_ireq_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL ar_wrap_addr: got %h expected fffffff8", w_ireq_addr); end
    n_checks++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL ar_ireq_valid_post: got %b expected 1", ireq_valid); end
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_refill_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL ar_refill_pc: got %h expected 00000000", out_pc); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_branch_redirect();
    test_dual_redirect();
    test_pc_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
